// File: rtl/divider_sequencer_if.sv
// Start/done handshake and result bus between a divider client and divider_sequencer.
interface divider_sequencer_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/divider_sequencer.sv
// Restoring-divider control and remainder/quotient datapath; steers an external
// 2*WIDTH divisor register that reloads on every clock edge.
module divider_sequencer #(
  parameter int unsigned WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  divider_sequencer_if.slave   bus,
  input  logic [2*WIDTH-1:0]   div_reg_q,
  output logic [2*WIDTH-1:0]   div_reg_d
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LOAD = 2'd1;
  localparam logic [1:0] ITER = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  localparam int unsigned CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH);

  logic [1:0]         state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0]   q_q, q_d;
  logic [WIDTH-1:0]   dsr_q, dsr_d;
  logic [WIDTH-1:0]   quot_q, quot_d;
  logic [WIDTH-1:0]   remo_q, remo_d;
  logic               dbz_q, dbz_d;
  logic [2*WIDTH:0]   diff;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    q_d       = q_q;
    dsr_d     = dsr_q;
    quot_d    = quot_q;
    remo_d    = remo_q;
    dbz_d     = dbz_q;
    div_reg_d = div_reg_q;
    // Extra top bit acts as the borrow: set means the trial subtraction went negative.
    diff      = {1'b0, rem_q} - {1'b0, div_reg_q};

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          dsr_d = bus.divisor;
          if (bus.divisor != '0) begin
            state_d = LOAD;
            rem_d   = {{WIDTH{1'b0}}, bus.dividend};
            q_d     = '0;
            dbz_d   = 1'b0;
          end else begin
            state_d = DONE;
            quot_d  = '1;
            remo_d  = bus.dividend;
            dbz_d   = 1'b1;
          end
        end
      end
      LOAD: begin
        div_reg_d = {dsr_q, {WIDTH{1'b0}}};
        cnt_d     = '0;
        state_d   = ITER;
      end
      ITER: begin
        div_reg_d = div_reg_q >> 1;
        if (!diff[2*WIDTH]) begin
          rem_d = diff[2*WIDTH-1:0];
        end
        q_d   = {q_q[WIDTH-2:0], ~diff[2*WIDTH]};
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          state_d = DONE;
          quot_d  = q_d;
          remo_d  = rem_d[WIDTH-1:0];
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (reset) begin
      div_reg_d = div_reg_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      q_q     <= '0;
      dsr_q   <= '0;
      quot_q  <= '0;
      remo_q  <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      q_q     <= q_d;
      dsr_q   <= dsr_d;
      quot_q  <= quot_d;
      remo_q  <= remo_d;
      dbz_q   <= dbz_d;
    end
  end

  assign bus.busy        = (state_q != IDLE);
  assign bus.done        = (state_q == DONE);
  assign bus.quotient    = quot_q;
  assign bus.remainder   = remo_q;
  assign bus.div_by_zero = dbz_q;
endmodule

// File: tb/tb_divider_sequencer.sv
// Bench for divider_sequencer looped through a modelled divisor register, checked
// against plain integer division.
module tb_divider_sequencer;
  localparam int unsigned WIDTH = 32;
  localparam int unsigned LAT   = WIDTH + 3;

  logic               clk;
  logic               reset;
  logic [2*WIDTH-1:0] div_reg_q;
  logic [2*WIDTH-1:0] div_reg_d;

  int unsigned n_checks;
  int unsigned n_errors;

  divider_sequencer_if #(.WIDTH(WIDTH)) bus ();

  divider_sequencer #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .div_reg_q (div_reg_q),
    .div_reg_d (div_reg_d)
  );

  // divisor_register: plain 2*WIDTH flop that loads data_in on every edge
  always_ff @(posedge clk) begin
    div_reg_q <= div_reg_d;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: ordinary integer division, all-ones quotient on a zero divisor.
  task automatic ref_div(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         output logic [WIDTH-1:0] q, output logic [WIDTH-1:0] r);
    if (b == 0) begin
      q = '1;
      r = a;
    end else begin
      q = a / b;
      r = a % b;
    end
  endtask

  task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input string tag);
    logic [WIDTH-1:0] eq, er;
    int n;
    ref_div(a, b, eq, er);
    @(negedge clk);
    bus.start    = 1'b1;
    bus.dividend = a;
    bus.divisor  = b;
    @(negedge clk);
    bus.start = 1'b0;
    n = 1;
    chk({tag, ".busy"}, 64'(bus.busy), 64'd1);
    while (!bus.done && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk({tag, ".latency"}, 64'(n), (b == 0) ? 64'd1 : 64'(LAT));
    chk({tag, ".quot"}, 64'(bus.quotient), 64'(eq));
    chk({tag, ".rem"}, 64'(bus.remainder), 64'(er));
    chk({tag, ".dbz"}, 64'(bus.div_by_zero), (b == 0) ? 64'd1 : 64'd0);
    @(negedge clk);
    chk({tag, ".done_pulse"}, 64'(bus.done), 64'd0);
    chk({tag, ".idle"}, 64'(bus.busy), 64'd0);
  endtask

  initial begin
    int n, pulses;
    logic [WIDTH-1:0] a, b;
    n_checks     = 0;
    n_errors     = 0;
    reset        = 1'b1;
    bus.start    = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;
    repeat (2) @(negedge clk);
    chk("rst.busy", 64'(bus.busy), 64'd0);
    chk("rst.done", 64'(bus.done), 64'd0);
    chk("rst.quot", 64'(bus.quotient), 64'd0);
    chk("rst.rem", 64'(bus.remainder), 64'd0);
    chk("rst.dbz", 64'(bus.div_by_zero), 64'd0);
    reset = 1'b0;

    run_op(32'd100, 32'd7, "t1");
    run_op(32'hFFFF_FFFF, 32'd1, "t2a");
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, "t2b");
    run_op(32'd5, 32'd0, "t3a");
    run_op(32'd9, 32'd3, "t3b");
    run_op(32'd3, 32'd10, "t4a");
    run_op(32'd0, 32'd7, "t4b");

    // start while busy must be ignored
    @(negedge clk);
    bus.start = 1'b1; bus.dividend = 32'd1000; bus.divisor = 32'd33;
    pulses = 0;
    for (int i = 1; i <= 45; i++) begin
      @(negedge clk);
      if (i == 11) begin
        bus.start = 1'b1; bus.dividend = 32'd50; bus.divisor = 32'd5;
      end else begin
        bus.start = 1'b0;
      end
      if (bus.done) begin
        pulses++;
        chk("t5.quot", 64'(bus.quotient), 64'd30);
        chk("t5.rem", 64'(bus.remainder), 64'd10);
      end
    end
    chk("t5.pulses", 64'(pulses), 64'd1);

    // asynchronous abort mid-iteration
    @(negedge clk);
    bus.start = 1'b1; bus.dividend = 32'd1000; bus.divisor = 32'd33;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (13) @(negedge clk);
    chk("t6.busy_before", 64'(bus.busy), 64'd1);
    #2 reset = 1'b1;
    #1;
    chk("t6.busy", 64'(bus.busy), 64'd0);
    chk("t6.done", 64'(bus.done), 64'd0);
    chk("t6.quot", 64'(bus.quotient), 64'd0);
    chk("t6.rem", 64'(bus.remainder), 64'd0);
    pulses = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (bus.done) pulses++;
    end
    reset = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.done) pulses++;
    end
    chk("t6.no_done", 64'(pulses), 64'd0);
    run_op(32'd77, 32'd7, "t6b");

    // start held high through DONE is re-accepted in the following IDLE cycle
    @(negedge clk);
    bus.start = 1'b1; bus.dividend = 32'd20; bus.divisor = 32'd4;
    n = 0;
    while (!bus.done && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("b2b.latency", 64'(n), 64'(LAT));
    chk("b2b.quot", 64'(bus.quotient), 64'd5);
    @(negedge clk);
    chk("b2b.idle", 64'(bus.busy), 64'd0);
    @(negedge clk);
    chk("b2b.reaccept", 64'(bus.busy), 64'd1);
    bus.start = 1'b0;
    n = 0;
    while (!bus.done && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("b2b.done2", 64'(bus.done), 64'd1);
    chk("b2b.quot2", 64'(bus.quotient), 64'd5);

    for (int i = 0; i < 25; i++) begin
      a = $urandom;
      case ($urandom_range(0, 3))
        0: b = 32'($urandom_range(0, 15));
        1: b = $urandom >> $urandom_range(0, 31);
        2: b = a + 32'($urandom_range(0, 3));
        default: b = $urandom;
      endcase
      run_op(a, b, "rnd");
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/divider_sequencer.md
Name: divider_sequencer

Overview:
Control and remainder/quotient datapath for the structural restoring divider. It sits in a loop around divisor_register. It drives the divisor register's data_in with the initial left-aligned divisor, then shifts it right one place per iteration. It consumes the register's data_out for the trial subtraction and produces a WIDTH-bit quotient and remainder with a start/done handshake.

Parameters:
WIDTH, 32, operand width; the divisor register and the internal remainder are 2*WIDTH (64) bits.

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
start  input  1  request a division; sampled only in IDLE
dividend  input  WIDTH  dividend, sampled when start is accepted
divisor  input  WIDTH  divisor, sampled when start is accepted
div_reg_q  input  2*WIDTH  current divisor register contents (divisor_register data_out)
div_reg_d  output  2*WIDTH  next divisor register value (divisor_register data_in)
busy  output  1  high from start acceptance until the cycle done is asserted, inclusive
done  output  1  one-cycle pulse: results valid
quotient  output  WIDTH  registered quotient
remainder  output  WIDTH  registered remainder
div_by_zero  output  1  registered flag for the last operation

Behaviour:
- Interface: one clock, clk. reset is asynchronous and active-high. On reset:
  - state=IDLE, iteration counter=0, internal 2*WIDTH remainder register=0.
  - quotient=0, remainder=0, done=0, busy=0, div_by_zero=0.
- divisor_register loads on every edge, so div_reg_d is combinational from state:
  - IDLE and DONE: div_reg_d = div_reg_q (hold).
  - LOAD: div_reg_d = {divisor_latched, WIDTH'b0}.
  - ITER: div_reg_d = div_reg_q >> 1 (logical shift).
  - Under reset: div_reg_d = div_reg_q.
- States:
  - IDLE: start=1 at an edge latches dividend and divisor.
    - If divisor≠0: go to LOAD; internal remainder={WIDTH'b0, dividend}; quotient register=0; div_by_zero cleared.
    - If divisor==0: go to DONE; quotient=all ones; remainder=dividend; div_by_zero=1.
  - LOAD: one cycle, so the divisor register captures the aligned divisor. Counter=0. Go to ITER.
  - ITER: one iteration per cycle, WIDTH+1 (33) iterations, counter 0..WIDTH.
    - diff = rem − div_reg_q, computed 2*WIDTH+1 bits wide; sign = bit 2*WIDTH.
    - sign=0: rem<=diff; q<={q[WIDTH-2:0],1}.
    - sign=1: rem unchanged (restore); q<={q[WIDTH-2:0],0}.
    - Counter increments. After the iteration with counter==WIDTH, go to DONE.
  - DONE: one cycle with done=1. Return to IDLE.
- Result registers:
  - quotient and remainder (rem[WIDTH-1:0]) output registers update on the edge entering DONE.
  - They hold until the next accepted start; they are not cleared at start.
- Latency:
  - Start accepted at edge E → done high during the cycle after edge E+WIDTH+2 (34 edges for WIDTH=32). Total 35 cycles start→done inclusive.
  - Divide-by-zero: done in the cycle after edge E.
- busy = (state≠IDLE).
- start while busy: ignored, no effect.
- start held high through DONE: accepted again in the next IDLE cycle (back-to-back ops allowed).
- Reset mid-operation: immediate return to IDLE with the reset values above; no done pulse. The divisor register's contents are don't-care after abort, because LOAD re-initialises it.
- Dividend < divisor: quotient=0, remainder=dividend. Dividend=0: quotient=0, remainder=0.

Test Plan:
1. Bench wires div_reg_d/div_reg_q through divisor_register. start with 100/7 → done 35 cycles after start; quotient=14, remainder=2, div_by_zero=0.
2. 0xFFFFFFFF/1 → quotient=0xFFFFFFFF, remainder=0. Then 0xFFFFFFFF/0xFFFFFFFF → quotient=1, remainder=0.
3. 5/0 → done on the 2nd cycle; quotient=0xFFFFFFFF, remainder=5, div_by_zero=1. Next op 9/3 → div_by_zero=0, quotient=3, remainder=0.
4. 3/10 → quotient=0, remainder=3. Then 0/7 → quotient=0, remainder=0.
5. start 1000/33; pulse start with 50/5 at iteration 10 → second start ignored; result quotient=30, remainder=10; exactly one done pulse.
6. Assert reset asynchronously (mid-cycle) at iteration 12 of 1000/33 → busy, done, quotient, remainder=0 immediately with no done pulse. After release, 77/7 → quotient=11, remainder=0.
